stdp_synapse_array: RTL

STDP_SYNAPSE_ARRAY -- requirements
Module: stdp_synapse_array

---
 rtl/stdp_pkg.sv | 35 +++
 rtl/stdp_synapse_array_lif_neuron.sv | 44 ++++
 rtl/stdp_synapse_array.sv | 125 ++++++++++++
 3 files changed

// File: rtl/stdp_pkg.sv
// Shared constants and saturating arithmetic for the STDP synapse array.
// Helpers work on 32-bit operands; callers cast to their own widths.
package stdp_pkg;

  localparam int N_PRE_D      = 4;
  localparam int W_BITS_D     = 4;
  localparam int STATE_BITS_D = 8;
  localparam int TRACE_BITS_D = 3;
  localparam int LEAK_SHIFT_D = 3;
  localparam int W_INIT_D     = 8;

  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_POT,
    UPD_DEP
  } upd_e;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] lim
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, lim}) ? lim : s[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/stdp_synapse_array_lif_neuron.sv
// Leaky integrate-and-fire neuron with registered spike and
// saturating membrane update.
module lif_neuron
  import stdp_pkg::*;
#(
  parameter int STATE_BITS = STATE_BITS_D,
  parameter int LEAK_SHIFT = LEAK_SHIFT_D
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STATE_BITS-1:0] i_current,
  input  logic [STATE_BITS-1:0] i_threshold,
  output logic                  o_spike,
  output logic [STATE_BITS-1:0] o_v
);

  localparam logic [31:0] V_MAX = 32'((64'd1 << STATE_BITS) - 1);

  logic [STATE_BITS-1:0] r_v;
  logic                  r_spike;
  logic [STATE_BITS-1:0] w_leaked;
  logic [STATE_BITS-1:0] w_next;

  // v - (v >> k) never underflows, so only the add needs clamping
  assign w_leaked = r_v - (r_v >> LEAK_SHIFT);
  assign w_next   = STATE_BITS'(sat_add(32'(w_leaked), 32'(i_current), V_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v     <= '0;
      r_spike <= 1'b0;
    end else if (r_v >= i_threshold) begin
      r_v     <= '0;
      r_spike <= 1'b1;
    end else begin
      r_v     <= w_next;
      r_spike <= 1'b0;
    end
  end

  assign o_spike = r_spike;
  assign o_v     = r_v;

endmodule

// File: rtl/stdp_synapse_array.sv
// Presynaptic LIF layer feeding one postsynaptic neuron through
// weights adapted by pair-based STDP with decaying timing traces.
module stdp_synapse_array
  import stdp_pkg::*;
#(
  parameter int N_PRE      = N_PRE_D,
  parameter int W_BITS     = W_BITS_D,
  parameter int STATE_BITS = STATE_BITS_D,
  parameter int TRACE_BITS = TRACE_BITS_D,
  parameter int LEAK_SHIFT = LEAK_SHIFT_D,
  parameter int W_INIT     = W_INIT_D,
  localparam int SEL_BITS  = (N_PRE > 1) ? $clog2(N_PRE) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [STATE_BITS-1:0]       current,
  input  logic [N_PRE*STATE_BITS-1:0] pre_threshold,
  input  logic [STATE_BITS-1:0]       post_threshold,
  input  logic                        learn_en,
  input  logic                        w_load,
  input  logic [SEL_BITS-1:0]         w_sel,
  input  logic [W_BITS-1:0]           w_data,
  output logic [N_PRE-1:0]            spike_pre,
  output logic                        spike_post,
  output logic [STATE_BITS-1:0]       post_state,
  output logic [N_PRE*W_BITS-1:0]     weights,
  output logic                        w_changed
);

  localparam logic [31:0] V_MAX  = 32'((64'd1 << STATE_BITS) - 1);
  localparam logic [31:0] W_MAX  = 32'((64'd1 << W_BITS) - 1);
  localparam logic [TRACE_BITS-1:0] TR_MAX = '1;

  logic [TRACE_BITS-1:0] r_post_tr;
  logic [N_PRE-1:0]      w_chg;
  logic [31:0]           w_sum;
  logic [STATE_BITS-1:0] w_post_i;

  for (genvar g = 0; g < N_PRE; g++) begin : g_ch
    logic [W_BITS-1:0]     r_w;
    logic [W_BITS-1:0]     w_learn;
    logic [TRACE_BITS-1:0] r_tr;
    logic [STATE_BITS-1:0] w_unused_v;
    logic                  w_hit;
    upd_e                  w_upd;

    lif_neuron #(
      .STATE_BITS(STATE_BITS),
      .LEAK_SHIFT(LEAK_SHIFT)
    ) u_pre (
      .clk        (clk),
      .rst        (rst),
      .i_current  (current),
      .i_threshold(pre_threshold[g*STATE_BITS +: STATE_BITS]),
      .o_spike    (spike_pre[g]),
      .o_v        (w_unused_v)
    );

    // Traces are read pre-edge; coincident spikes cancel out
    always_comb begin
      w_upd = UPD_NONE;
      if (learn_en && spike_post && !spike_pre[g] && (r_tr != '0))
        w_upd = UPD_POT;
      else if (learn_en && spike_pre[g] && !spike_post && (r_post_tr != '0))
        w_upd = UPD_DEP;
    end

    always_comb begin
      w_learn = r_w;
      unique case (w_upd)
        UPD_POT: w_learn = W_BITS'(sat_add(32'(r_w), 32'd1, W_MAX));
        UPD_DEP: w_learn = W_BITS'(sat_sub(32'(r_w), 32'd1));
        default: w_learn = r_w;
      endcase
    end

    assign w_hit    = w_load && (int'(w_sel) == g);
    assign w_chg[g] = !w_hit && (w_learn != r_w);
    assign weights[g*W_BITS +: W_BITS] = r_w;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_w  <= W_BITS'(W_INIT);
        r_tr <= '0;
      end else begin
        r_w  <= w_hit ? w_data : w_learn;
        r_tr <= spike_pre[g] ? TR_MAX :
                (r_tr != '0) ? r_tr - 1'b1 : '0;
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_PRE; i++)
      if (spike_pre[i])
        w_sum = sat_add(w_sum, 32'(weights[i*W_BITS +: W_BITS]), V_MAX);
  end

  assign w_post_i = STATE_BITS'(w_sum);

  lif_neuron #(
    .STATE_BITS(STATE_BITS),
    .LEAK_SHIFT(LEAK_SHIFT)
  ) u_post (
    .clk        (clk),
    .rst        (rst),
    .i_current  (w_post_i),
    .i_threshold(post_threshold),
    .o_spike    (spike_post),
    .o_v        (post_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_post_tr <= '0;
      w_changed <= 1'b0;
    end else begin
      r_post_tr <= spike_post ? TR_MAX :
                   (r_post_tr != '0) ? r_post_tr - 1'b1 : '0;
      w_changed <= |w_chg;
    end
  end

endmodule
